// File: rtl/tape_pkg.sv
// Shared types for the bf data-tape controller: command opcodes, controller states, tape size.
package tape_pkg;

  localparam int TAPE_DEPTH = 256;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,
    OP_DEC   = 3'd2,
    OP_RIGHT = 3'd3,
    OP_LEFT  = 3'd4,
    OP_READ  = 3'd5,
    OP_WRITE = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SWEEP   = 2'd0,
    IDLE    = 2'd1,
    FETCH   = 2'd2,
    CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/tape_controller.sv
// Data-pointer owner for the bf tape RAM: caches the cell under the pointer, executes
// single tape commands, and zeroes the whole tape after reset or CLEAR.
module tape_controller
  import tape_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              cell_zero,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] sweep_cnt_reg, sweep_cnt_next;
  logic [DATA_W-1:0] cur_reg, cur_next;
  logic              cmd_ready_reg, cmd_ready_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic [ADDR_W-1:0] mem_address_reg, mem_address_next;
  logic [DATA_W-1:0] mem_data_reg, mem_data_next;
  logic              mem_wren_reg, mem_wren_next;
  logic              accept;

  assign accept = cmd_valid && cmd_ready_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= SWEEP;
      ptr_reg         <= '0;
      sweep_cnt_reg   <= '0;
      cur_reg         <= '0;
      cmd_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= '0;
      mem_address_reg <= '0;
      mem_data_reg    <= '0;
      mem_wren_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      sweep_cnt_reg   <= sweep_cnt_next;
      cur_reg         <= cur_next;
      cmd_ready_reg   <= cmd_ready_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_data_reg    <= rsp_data_next;
      mem_address_reg <= mem_address_next;
      mem_data_reg    <= mem_data_next;
      mem_wren_reg    <= mem_wren_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    sweep_cnt_next   = sweep_cnt_reg;
    cur_next         = cur_reg;
    cmd_ready_next   = cmd_ready_reg;
    rsp_valid_next   = 1'b0;
    rsp_data_next    = rsp_data_reg;
    mem_address_next = mem_address_reg;
    mem_data_next    = mem_data_reg;
    mem_wren_next    = 1'b0;

    case (state_reg)
      SWEEP: begin
        mem_wren_next    = 1'b1;
        mem_data_next    = '0;
        mem_address_next = sweep_cnt_reg;
        sweep_cnt_next   = sweep_cnt_reg + 1'b1;
        if (&sweep_cnt_reg) begin
          state_next     = IDLE;
          cmd_ready_next = 1'b1;
          ptr_next       = '0;
          cur_next       = '0;
        end
      end
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_INC, OP_DEC, OP_WRITE: begin
              if (cmd_op == OP_INC)      cur_next = cur_reg + 1'b1;
              else if (cmd_op == OP_DEC) cur_next = cur_reg - 1'b1;
              else                       cur_next = cmd_wdata;
              mem_address_next = ptr_reg;
              mem_data_next    = cur_next;
              mem_wren_next    = 1'b1;
            end
            OP_RIGHT, OP_LEFT: begin
              // Any write issued last cycle still hits the old cell before this fetch reads.
              ptr_next         = (cmd_op == OP_RIGHT) ? ptr_reg + 1'b1 : ptr_reg - 1'b1;
              mem_address_next = ptr_next;
              cmd_ready_next   = 1'b0;
              state_next       = FETCH;
            end
            OP_READ: begin
              rsp_valid_next = 1'b1;
              rsp_data_next  = cur_reg;
            end
            OP_CLEAR: begin
              cmd_ready_next = 1'b0;
              sweep_cnt_next = '0;
              state_next     = SWEEP;
            end
            default: ;
          endcase
        end
      end
      FETCH: state_next = CAPTURE;
      CAPTURE: begin
        cur_next       = mem_q;
        cmd_ready_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = SWEEP;
    endcase
  end

  assign cmd_ready   = cmd_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign cell_zero   = (cur_reg == '0);
  assign ptr         = ptr_reg;
  assign mem_address = mem_address_reg;
  assign mem_data    = mem_data_reg;
  assign mem_wren    = mem_wren_reg;

endmodule

// File: tb/tb_tape_controller.sv
// Bench for tape_controller with a behavioural tape RAM; directed table, reset/sweep
// sequences and random commands checked against an array model of the tape.
module tb_tape_controller;
  import tape_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       cell_zero;
  logic [7:0] ptr;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_wren;
  logic [7:0] mem_q;

  logic [7:0] ram [TAPE_DEPTH];

  // model of the tape contents and pointer
  logic [7:0] m [TAPE_DEPTH];
  logic [7:0] mptr;

  int n_vec  = 0;
  int n_miss = 0;

  logic       last_rv;
  logic [7:0] last_rd;
  int         last_busy;
  logic [7:0] exp_rd;

  typedef struct {
    logic [2:0] op;
    logic [7:0] wd;
    logic       exp_rv;
    logic [7:0] exp_rd;
    int         exp_busy;
    logic [7:0] exp_ptr;
    logic       exp_zero;
  } vec_t;

  vec_t tbl [26];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  tape_controller #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cell_zero(cell_zero), .ptr(ptr),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAPE_DEPTH; i++) m[i] = 8'd0;
    mptr = 8'd0;
  endtask

  // Issue one command when ready; returns the response seen the cycle after accept
  // and how many cycles cmd_ready stayed low afterwards.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] wd,
                        output logic rv, output logic [7:0] rd, output int busy);
    int w;
    w = 0;
    while (!cmd_ready && w < 1000) begin
      @(negedge clock);
      w++;
    end
    if (!cmd_ready) begin
      $display("FAIL cmd_wait: got timeout, expected cmd_ready");
      $fatal(1, "cmd_ready never rose");
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    rv   = rsp_valid;
    rd   = rsp_data;
    busy = 0;
    while (!cmd_ready && busy < 1000) begin
      @(negedge clock);
      busy++;
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] wd);
    exp_rd = m[mptr];
    do_cmd(op, wd, last_rv, last_rd, last_busy);
    case (op)
      OP_INC:   m[mptr] = m[mptr] + 8'd1;
      OP_DEC:   m[mptr] = m[mptr] - 8'd1;
      OP_WRITE: m[mptr] = wd;
      OP_RIGHT: mptr = mptr + 8'd1;
      OP_LEFT:  mptr = mptr - 8'd1;
      OP_CLEAR: model_clear();
      default: ;
    endcase
  endtask

  task automatic reset_seq(output int edges);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    edges = 0;
    while (edges < 1000) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (cmd_ready) break;
    end
    model_clear();
  endtask

  // one idle cycle lets the last registered write land, then compare the whole tape
  task automatic dump_check(input string name);
    int bad;
    @(posedge clock);
    @(negedge clock);
    bad = 0;
    for (int i = 0; i < TAPE_DEPTH; i++) begin
      if (ram[i] !== m[i]) begin
        if (bad == 0) $display("FAIL %s_cell%0d: got %0d, expected %0d", name, i, ram[i], m[i]);
        bad++;
      end
    end
    check({name, "_bad_cells"}, bad, 0);
  endtask

  function automatic vec_t row(input logic [2:0] op, input logic [7:0] wd, input logic rv,
                               input logic [7:0] rd, input int busy, input logic [7:0] p,
                               input logic z);
    vec_t v;
    v.op = op; v.wd = wd; v.exp_rv = rv; v.exp_rd = rd;
    v.exp_busy = busy; v.exp_ptr = p; v.exp_zero = z;
    return v;
  endfunction

  initial begin
    int edges;
    logic [2:0] op;
    logic [7:0] wd;

    tbl[0]  = row(OP_INC,   8'h00, 0, 8'h00, 0, 8'd0,   0);
    tbl[1]  = row(OP_INC,   8'h00, 0, 8'h00, 0, 8'd0,   0);
    tbl[2]  = row(OP_INC,   8'h00, 0, 8'h00, 0, 8'd0,   0);
    tbl[3]  = row(OP_READ,  8'h00, 1, 8'd3,  0, 8'd0,   0);
    tbl[4]  = row(OP_RIGHT, 8'h00, 0, 8'h00, 2, 8'd1,   1);
    tbl[5]  = row(OP_DEC,   8'h00, 0, 8'h00, 0, 8'd1,   0);
    tbl[6]  = row(OP_READ,  8'h00, 1, 8'd255, 0, 8'd1,  0);
    tbl[7]  = row(OP_LEFT,  8'h00, 0, 8'h00, 2, 8'd0,   0);
    tbl[8]  = row(OP_WRITE, 8'h41, 0, 8'h00, 0, 8'd0,   0);
    tbl[9]  = row(OP_RIGHT, 8'h00, 0, 8'h00, 2, 8'd1,   0);
    tbl[10] = row(OP_WRITE, 8'h07, 0, 8'h00, 0, 8'd1,   0);
    tbl[11] = row(OP_LEFT,  8'h00, 0, 8'h00, 2, 8'd0,   0);
    tbl[12] = row(OP_READ,  8'h00, 1, 8'h41, 0, 8'd0,   0);
    tbl[13] = row(OP_LEFT,  8'h00, 0, 8'h00, 2, 8'd255, 1);
    tbl[14] = row(OP_INC,   8'h00, 0, 8'h00, 0, 8'd255, 0);
    tbl[15] = row(OP_RIGHT, 8'h00, 0, 8'h00, 2, 8'd0,   0);
    tbl[16] = row(OP_READ,  8'h00, 1, 8'h41, 0, 8'd0,   0);
    tbl[17] = row(OP_LEFT,  8'h00, 0, 8'h00, 2, 8'd255, 0);
    tbl[18] = row(OP_READ,  8'h00, 1, 8'd1,  0, 8'd255, 0);
    tbl[19] = row(OP_RIGHT, 8'h00, 0, 8'h00, 2, 8'd0,   0);
    tbl[20] = row(OP_INC,   8'h00, 0, 8'h00, 0, 8'd0,   0);
    tbl[21] = row(OP_RIGHT, 8'h00, 0, 8'h00, 2, 8'd1,   0);
    tbl[22] = row(OP_READ,  8'h00, 1, 8'h07, 0, 8'd1,   0);
    tbl[23] = row(OP_LEFT,  8'h00, 0, 8'h00, 2, 8'd0,   0);
    tbl[24] = row(OP_READ,  8'h00, 1, 8'h42, 0, 8'd0,   0);
    tbl[25] = row(OP_NOP,   8'h00, 0, 8'h00, 0, 8'd0,   0);

    // garbage in the RAM proves the sweep, not the RAM, zeroes the tape
    for (int i = 0; i < TAPE_DEPTH; i++) ram[i] = 8'($urandom);
    model_clear();

    reset_seq(edges);
    check("reset_ready_latency", edges, 256);
    check("reset_ptr", ptr, 0);
    check("reset_cell_zero", cell_zero, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    dump_check("reset_dump");

    for (int i = 0; i < 26; i++) begin
      run(tbl[i].op, tbl[i].wd);
      check($sformatf("row%0d_rsp_valid", i), last_rv, tbl[i].exp_rv);
      if (tbl[i].exp_rv) check($sformatf("row%0d_rsp_data", i), last_rd, tbl[i].exp_rd);
      check($sformatf("row%0d_busy", i), last_busy, tbl[i].exp_busy);
      check($sformatf("row%0d_ptr", i), ptr, tbl[i].exp_ptr);
      check($sformatf("row%0d_cell_zero", i), cell_zero, tbl[i].exp_zero);
    end

    // rsp_valid is a single-cycle pulse
    run(OP_READ, 8'h00);
    @(negedge clock);
    check("read_pulse_drop", rsp_valid, 0);

    dump_check("table_dump");
    check("ram0_value", ram[0], 8'h42);
    check("ram1_value", ram[1], 8'h07);
    check("ram255_value", ram[255], 8'h01);

    // CLEAR mid-program, then reset 100 edges into that sweep
    run(OP_WRITE, 8'h55);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLEAR;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("clear_ready_low", cmd_ready, 0);
    repeat (100) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_reset_wren", mem_wren, 0);
    check("async_reset_addr", mem_address, 0);
    check("async_reset_ptr", ptr, 0);
    reset_seq(edges);
    check("resweep_ready_latency", edges, 256);
    check("resweep_ptr", ptr, 0);
    check("resweep_cell_zero", cell_zero, 1);
    dump_check("resweep_dump");

    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 6));
      wd = 8'($urandom);
      run(op, wd);
      check($sformatf("rnd%0d_rsp_valid", i), last_rv, (op == OP_READ));
      if (op == OP_READ) check($sformatf("rnd%0d_rsp_data", i), last_rd, exp_rd);
      check($sformatf("rnd%0d_busy", i), last_busy, (op == OP_RIGHT || op == OP_LEFT) ? 2 : 0);
      check($sformatf("rnd%0d_ptr", i), ptr, mptr);
      check($sformatf("rnd%0d_cell_zero", i), cell_zero, (m[mptr] == 8'd0));
    end
    dump_check("random_dump");

    // CLEAR via the command path re-zeroes everything written above
    run(OP_CLEAR, 8'h00);
    check("clear_busy", last_busy, 256);
    check("clear_ptr", ptr, 0);
    check("clear_cell_zero", cell_zero, 1);
    dump_check("clear_dump");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
